// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the memory-stage load/store unit:
//   - lsu_state_t : transaction FSM states (IDLE, REQ, WAIT, DONE)
//   - F3_*        : RV32I load/store width codes (funct3)
//   - LOAD/STORE  : major opcodes used by the decoder that drives M_load/M_store
// -----------------------------------------------------------------------------
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011;

endpackage

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Purely combinational byte-lane logic for the load/store unit.
//   is_store : 1 = classify/steer as a store, 0 = as a load
//   funct3   : RV32I width code
//   offset   : byte offset inside the word (addr[1:0])
//   data     : store data (store use) or memory read word (load use)
//   wdata    : lane-replicated store data (0 for loads)
//   bweb     : active-low per-bit write mask (all ones for loads)
//   ldata    : selected and sign/zero-extended load value
//   legal    : funct3 is a valid code for this access type
//   aligned  : offset is naturally aligned for the access width
// -----------------------------------------------------------------------------
module lsu_align
    import lsu_pkg::*;
(
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] data,
    output logic [31:0] wdata,
    output logic [31:0] bweb,
    output logic [31:0] ldata,
    output logic        legal,
    output logic        aligned
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        legal = 1'b0;
        case (funct3)
            F3_B, F3_H, F3_W: legal = 1'b1;
            F3_BU, F3_HU:     legal = ~is_store;
            default:          legal = 1'b0;
        endcase
    end

    // Width comes from funct3[1:0] for both signed and unsigned variants.
    always_comb begin
        aligned = 1'b1;
        case (funct3[1:0])
            2'b01:   aligned = ~offset[0];
            2'b10:   aligned = (offset == 2'b00);
            default: aligned = 1'b1;
        endcase
    end

    // Data is replicated on every lane so memory only needs the mask to
    // pick the right bytes; the mask clears exactly the written lanes.
    always_comb begin
        wdata = '0;
        bweb  = '1;
        if (is_store) begin
            case (funct3)
                F3_B: begin
                    wdata                       = {4{data[7:0]}};
                    bweb[{offset, 3'b000} +: 8] = 8'h00;
                end
                F3_H: begin
                    wdata                           = {2{data[15:0]}};
                    bweb[{offset[1], 4'b0000} +: 16] = 16'h0000;
                end
                F3_W: begin
                    wdata = data;
                    bweb  = '0;
                end
                default: begin
                    wdata = '0;
                    bweb  = '1;
                end
            endcase
        end
    end

    assign sel_byte = data[{offset, 3'b000} +: 8];
    assign sel_half = data[{offset[1], 4'b0000} +: 16];

    always_comb begin
        ldata = data;
        case (funct3)
            F3_B:    ldata = {{24{sel_byte[7]}}, sel_byte};
            F3_H:    ldata = {{16{sel_half[15]}}, sel_half};
            F3_BU:   ldata = {24'h000000, sel_byte};
            F3_HU:   ldata = {16'h0000, sel_half};
            default: ldata = data;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// -----------------------------------------------------------------------------
// mem_stage_lsu
// Memory-stage load/store unit between the EX/MEM and MEM/WB registers. Takes
// one memory instruction from EX/MEM, runs a single valid/ready request on the
// data-memory port and, for loads, waits for the response and delivers the
// extended result. The pipeline is frozen with lsu_stall until completion.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   M_valid/M_load/M_store/M_funct3/M_addr/M_store_data/M_rd
//                       EX/MEM register outputs describing the instruction
//   dm_req_valid/ready  request handshake to data memory
//   dm_addr             word-aligned address
//   dm_web, dm_bweb     active-low write strobe and per-bit write mask
//   dm_wdata            lane-steered store data
//   dm_rsp_valid/rdata  read response (only honoured while waiting for it)
//   lsu_stall           freeze upstream pipeline stages
//   W_load_valid/rd/data one-cycle load result to MEM/WB (rd/data hold)
//   lsu_fault           one-cycle pulse on illegal or misaligned access
// -----------------------------------------------------------------------------
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              M_valid,
    input  logic              M_load,
    input  logic              M_store,
    input  logic [2:0]        M_funct3,
    input  logic [31:0]       M_addr,
    input  logic [31:0]       M_store_data,
    input  logic [4:0]        M_rd,
    output logic              dm_req_valid,
    input  logic              dm_req_ready,
    output logic [ADDR_W-1:0] dm_addr,
    output logic              dm_web,
    output logic [31:0]       dm_bweb,
    output logic [31:0]       dm_wdata,
    input  logic              dm_rsp_valid,
    input  logic [31:0]       dm_rdata,
    output logic              lsu_stall,
    output logic              W_load_valid,
    output logic [4:0]        W_load_rd,
    output logic [31:0]       W_load_data,
    output logic              lsu_fault
);

    lsu_state_t  state, next_state;

    logic        op_presented;
    logic        op_legal;
    logic        op_aligned;
    logic        op_accept;

    logic [31:0] st_wdata;
    logic [31:0] st_bweb;
    logic [31:0] st_ldata;

    logic [2:0]  cap_funct3;
    logic [1:0]  cap_offset;
    logic [4:0]  cap_rd;
    logic        cap_store;

    logic [31:0] ld_data;
    logic [31:0] ld_wdata;
    logic [31:0] ld_bweb;
    logic        ld_legal;
    logic        ld_aligned;
    logic        unused_align;

    assign op_presented = M_valid && (M_load || M_store);
    assign op_accept    = (state == IDLE) && op_presented && op_legal && op_aligned;

    // Checks and steers the live instruction so the request can be launched
    // straight from registers in the next cycle.
    lsu_align u_store_align (
        .is_store (M_store),
        .funct3   (M_funct3),
        .offset   (M_addr[1:0]),
        .data     (M_store_data),
        .wdata    (st_wdata),
        .bweb     (st_bweb),
        .ldata    (st_ldata),
        .legal    (op_legal),
        .aligned  (op_aligned)
    );

    // Formats the returning read word using the captured width and offset.
    lsu_align u_load_align (
        .is_store (1'b0),
        .funct3   (cap_funct3),
        .offset   (cap_offset),
        .data     (dm_rdata),
        .wdata    (ld_wdata),
        .bweb     (ld_bweb),
        .ldata    (ld_data),
        .legal    (ld_legal),
        .aligned  (ld_aligned)
    );

    assign unused_align = ^{st_ldata, ld_wdata, ld_bweb, ld_legal, ld_aligned};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        lsu_stall    = 1'b0;
        dm_req_valid = 1'b0;
        case (state)
            IDLE: begin
                if (op_accept) begin
                    next_state = REQ;
                    lsu_stall  = 1'b1;
                end
            end
            REQ: begin
                dm_req_valid = 1'b1;
                lsu_stall    = 1'b1;
                if (dm_req_ready) begin
                    next_state = cap_store ? DONE : WAIT;
                end
            end
            WAIT: begin
                lsu_stall = 1'b1;
                if (dm_rsp_valid) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                // Stall released for one cycle so EX/MEM advances exactly once.
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        // Live M_* inputs must not freeze the pipeline while held in reset.
        if (rst) begin
            lsu_stall = 1'b0;
        end
    end

    // Request fields are registered at acceptance and held through REQ.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dm_addr    <= '0;
            dm_web     <= 1'b1;
            dm_bweb    <= '1;
            dm_wdata   <= '0;
            cap_funct3 <= '0;
            cap_offset <= '0;
            cap_rd     <= '0;
            cap_store  <= 1'b0;
        end else if (op_accept) begin
            dm_addr    <= {M_addr[ADDR_W-1:2], 2'b00};
            dm_web     <= ~M_store;
            dm_bweb    <= st_bweb;
            dm_wdata   <= st_wdata;
            cap_funct3 <= M_funct3;
            cap_offset <= M_addr[1:0];
            cap_rd     <= M_rd;
            cap_store  <= M_store;
        end
    end

    // Writeback and fault outputs; the load result registered here lines up
    // with the DONE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            W_load_valid <= 1'b0;
            W_load_rd    <= '0;
            W_load_data  <= '0;
            lsu_fault    <= 1'b0;
        end else begin
            lsu_fault    <= (state == IDLE) && op_presented && !(op_legal && op_aligned);
            W_load_valid <= 1'b0;
            if ((state == WAIT) && dm_rsp_valid) begin
                W_load_valid <= 1'b1;
                W_load_rd    <= cap_rd;
                W_load_data  <= ld_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
`timescale 1ns/1ps
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        M_valid, M_load, M_store;
    logic [2:0]  M_funct3;
    logic [31:0] M_addr, M_store_data;
    logic [4:0]  M_rd;
    logic        dm_req_valid, dm_req_ready;
    logic [31:0] dm_addr;
    logic        dm_web;
    logic [31:0] dm_bweb, dm_wdata;
    logic        dm_rsp_valid;
    logic [31:0] dm_rdata;
    logic        lsu_stall, W_load_valid, lsu_fault;
    logic [4:0]  W_load_rd;
    logic [31:0] W_load_data;

    always #5 clk = ~clk;

    mem_stage_lsu #(.ADDR_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .M_valid      (M_valid),
        .M_load       (M_load),
        .M_store      (M_store),
        .M_funct3     (M_funct3),
        .M_addr       (M_addr),
        .M_store_data (M_store_data),
        .M_rd         (M_rd),
        .dm_req_valid (dm_req_valid),
        .dm_req_ready (dm_req_ready),
        .dm_addr      (dm_addr),
        .dm_web       (dm_web),
        .dm_bweb      (dm_bweb),
        .dm_wdata     (dm_wdata),
        .dm_rsp_valid (dm_rsp_valid),
        .dm_rdata     (dm_rdata),
        .lsu_stall    (lsu_stall),
        .W_load_valid (W_load_valid),
        .W_load_rd    (W_load_rd),
        .W_load_data  (W_load_data),
        .lsu_fault    (lsu_fault)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Memory environment: reacts to whatever the DUT actually writes.
    int          hs_count = 0;
    logic [31:0] last_addr = '0;
    logic [31:0] env_mem [8192];
    bit          written [8192];

    // Reference memory contents, built from the architectural store rules.
    logic [31:0] ref_mem [int unsigned];

    // Expected held writeback values.
    logic [31:0] exp_w_data = '0;
    logic [4:0]  exp_w_rd   = '0;

    // Optional fixed read word for directed load cases.
    bit          ovr_en   = 1'b0;
    logic [31:0] ovr_word = '0;

    function automatic logic [31:0] fill(int unsigned idx);
        return (idx * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [31:0] env_word(logic [12:0] idx);
        return written[idx] ? env_mem[idx] : fill(32'(idx));
    endfunction

    function automatic logic [31:0] ref_word(int unsigned idx);
        return ref_mem.exists(idx) ? ref_mem[idx] : fill(idx);
    endfunction

    always @(posedge clk) begin
        if (!rst && dm_req_valid && dm_req_ready) begin
            hs_count  <= hs_count + 1;
            last_addr <= dm_addr;
            if (!dm_web) begin
                env_mem[dm_addr[14:2]] <= (env_word(dm_addr[14:2]) & dm_bweb) | (dm_wdata & ~dm_bweb);
                written[dm_addr[14:2]] <= 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic bit ref_legal(bit ld, bit st, logic [2:0] f3);
        if (ld) return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        if (st) return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
        return 1'b0;
    endfunction

    // Load result from plain arithmetic: shift, truncate to size, then
    // subtract 2^bits when a signed value has its top bit set.
    function automatic logic [31:0] ref_load(logic [2:0] f3, logic [1:0] off, logic [31:0] w);
        longint unsigned u;
        int              bits;
        bits = 8 * (1 << f3[1:0]);
        u = 64'(w) >> (8 * int'(off));
        u = u % (64'd1 << bits);
        if (!f3[2] && bits < 32 && u >= (64'd1 << (bits - 1)))
            u = u - (64'd1 << bits);
        return u[31:0];
    endfunction

    task automatic do_op(input bit ld, input bit st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sd,
                         input logic [4:0] rd, input int rdy_dly, input int rsp_dly);
        bit          ok;
        int          sz;
        int          off;
        int          hs0;
        logic [31:0] exp_bweb, exp_wdata, word, rdata;
        sz  = 1 << f3[1:0];
        off = int'(addr[1:0]);
        ok  = ref_legal(ld, st, f3) && ((addr % sz) == 0);
        hs0 = hs_count;

        exp_bweb  = '1;
        exp_wdata = sd;
        if (st && ok) begin
            if (sz == 1) exp_wdata = {4{sd[7:0]}};
            else if (sz == 2) exp_wdata = {2{sd[15:0]}};
            for (int i = 0; i < 4; i++)
                if (i >= off && i < off + sz) exp_bweb[8*i +: 8] = 8'h00;
        end

        next_cycle();
        M_valid = 1'b1; M_load = ld; M_store = st; M_funct3 = f3;
        M_addr = addr; M_store_data = sd; M_rd = rd;
        dm_req_ready = 1'b0; dm_rsp_valid = 1'($urandom_range(0, 1)); dm_rdata = $urandom;
        #1;
        chk("stall_c0", 32'(lsu_stall), 32'(ok));
        chk("reqv_c0", 32'(dm_req_valid), 0);
        chk("wvld_c0", 32'(W_load_valid), 0);
        chk("fault_c0", 32'(lsu_fault), 0);
        chk("wdata_hold", W_load_data, exp_w_data);
        chk("wrd_hold", 32'(W_load_rd), 32'(exp_w_rd));

        if (!ok) begin
            next_cycle();
            M_valid = 1'b0; dm_rsp_valid = 1'b0;
            #1;
            chk("fault", 32'(lsu_fault), 32'((ld || st)));
            chk("reqv_nf", 32'(dm_req_valid), 0);
            chk("stall_nf", 32'(lsu_stall), 0);
            chk("hs_none", 32'(hs_count - hs0), 0);
            return;
        end

        for (int n = 0; n <= rdy_dly; n++) begin
            next_cycle();
            dm_rsp_valid = 1'($urandom_range(0, 1)); dm_rdata = $urandom;
            #1;
            chk("reqv", 32'(dm_req_valid), 1);
            chk("stall_req", 32'(lsu_stall), 1);
            chk("addr", dm_addr, {addr[31:2], 2'b00});
            chk("web", 32'(dm_web), 32'(!st));
            chk("bweb", dm_bweb, exp_bweb);
            if (st) chk("wdata", dm_wdata, exp_wdata);
            if (n == rdy_dly) dm_req_ready = 1'b1;
        end

        next_cycle();
        dm_req_ready = 1'b0; dm_rsp_valid = 1'b0;
        if (st) begin
            M_valid = 1'b0;
            #1;
            chk("stall_sdone", 32'(lsu_stall), 0);
            chk("reqv_sdone", 32'(dm_req_valid), 0);
            chk("wvld_store", 32'(W_load_valid), 0);
            chk("hs_store", 32'(hs_count - hs0), 1);
            word = ref_word(addr >> 2);
            for (int i = 0; i < 4; i++)
                if (i >= off && i < off + sz) word[8*i +: 8] = sd[8*(i-off) +: 8];
            ref_mem[addr >> 2] = word;
        end else begin
            for (int m = 0; m <= rsp_dly; m++) begin
                if (m > 0) next_cycle();
                #1;
                chk("stall_wait", 32'(lsu_stall), 1);
                chk("reqv_wait", 32'(dm_req_valid), 0);
                chk("wvld_wait", 32'(W_load_valid), 0);
            end
            rdata = ovr_en ? ovr_word : env_word(last_addr[14:2]);
            word  = ovr_en ? ovr_word : ref_word(addr >> 2);
            dm_rsp_valid = 1'b1; dm_rdata = rdata;
            next_cycle();
            dm_rsp_valid = 1'b0; dm_rdata = $urandom; M_valid = 1'b0;
            #1;
            exp_w_data = ref_load(f3, addr[1:0], word);
            exp_w_rd   = rd;
            chk("wvld", 32'(W_load_valid), 1);
            chk("wrd", 32'(W_load_rd), 32'(rd));
            chk("wdata", W_load_data, exp_w_data);
            chk("stall_ldone", 32'(lsu_stall), 0);
            chk("reqv_ldone", 32'(dm_req_valid), 0);
            chk("hs_load", 32'(hs_count - hs0), 1);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_reqv"}, 32'(dm_req_valid), 0);
        chk({tag, "_web"}, 32'(dm_web), 1);
        chk({tag, "_bweb"}, dm_bweb, 32'hFFFFFFFF);
        chk({tag, "_addr"}, dm_addr, 0);
        chk({tag, "_wdata"}, dm_wdata, 0);
        chk({tag, "_wvld"}, 32'(W_load_valid), 0);
        chk({tag, "_wrd"}, 32'(W_load_rd), 0);
        chk({tag, "_wdat"}, W_load_data, 0);
        chk({tag, "_fault"}, 32'(lsu_fault), 0);
        chk({tag, "_stall"}, 32'(lsu_stall), 0);
    endtask

    task automatic reset_mid_wait();
        next_cycle();
        M_valid = 1'b1; M_load = 1'b1; M_store = 1'b0; M_funct3 = 3'd2;
        M_addr = 32'h2000; M_rd = 5'd17; dm_req_ready = 1'b0; dm_rsp_valid = 1'b0;
        #1;
        chk("rst_stall0", 32'(lsu_stall), 1);
        next_cycle();
        dm_req_ready = 1'b1;
        #1;
        chk("rst_reqv", 32'(dm_req_valid), 1);
        next_cycle();
        dm_req_ready = 1'b0;
        #1;
        chk("rst_in_wait", 32'(lsu_stall), 1);
        rst = 1'b1;
        #1;
        chk_reset_values("rst_mid");
        next_cycle();
        M_valid = 1'b0; rst = 1'b0;
        dm_rsp_valid = 1'b1; dm_rdata = 32'hDEADBEEF;
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            #1;
            chk("rst_late_wvld", 32'(W_load_valid), 0);
            chk("rst_late_reqv", 32'(dm_req_valid), 0);
            chk("rst_late_stall", 32'(lsu_stall), 0);
            chk("rst_late_wdat", W_load_data, 0);
        end
        dm_rsp_valid = 1'b0;
        exp_w_data = '0;
        exp_w_rd   = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time %0t reached limit %0t", $time, 2_000_000);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hs0;
        bit ld, st;
        logic [2:0] f3;
        int r;

        rst = 1'b1;
        M_valid = 1'b1; M_load = 1'b1; M_store = 1'b0; M_funct3 = 3'd2;
        M_addr = 32'h100; M_store_data = '0; M_rd = 5'd1;
        dm_req_ready = 1'b0; dm_rsp_valid = 1'b0; dm_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_values("reset");
        M_valid = 1'b0;
        rst = 1'b0;

        // SB lane steering
        do_op(1'b0, 1'b1, 3'd0, 32'h1001, 32'h000000A5, 5'd3, 0, 0);

        // LB / LBU of the top byte, LH with ready held off
        ovr_en = 1'b1;
        ovr_word = 32'h80FF1234;
        do_op(1'b1, 1'b0, 3'd0, 32'h2003, 32'h0, 5'd7, 0, 0);
        chk("lb_value", W_load_data, 32'hFFFFFF80);
        do_op(1'b1, 1'b0, 3'd4, 32'h2003, 32'h0, 5'd8, 0, 0);
        chk("lbu_value", W_load_data, 32'h00000080);
        ovr_word = 32'h7FFE0000;
        do_op(1'b1, 1'b0, 3'd1, 32'h2002, 32'h0, 5'd9, 3, 0);
        chk("lh_value", W_load_data, 32'h00007FFE);
        ovr_en = 1'b0;

        // Misaligned and illegal accesses
        do_op(1'b1, 1'b0, 3'd2, 32'h3001, 32'h0, 5'd4, 0, 0);
        do_op(1'b1, 1'b0, 3'd3, 32'h3000, 32'h0, 5'd4, 0, 0);
        do_op(1'b0, 1'b1, 3'd1, 32'h3003, 32'h1234, 5'd4, 0, 0);

        reset_mid_wait();

        // Back-to-back store then load of the same word
        hs0 = hs_count;
        do_op(1'b0, 1'b1, 3'd2, 32'h4000, 32'hCAFEF00D, 5'd0, 0, 0);
        do_op(1'b1, 1'b0, 3'd2, 32'h4000, 32'h0, 5'd12, 0, 0);
        chk("b2b_data", W_load_data, 32'hCAFEF00D);
        chk("b2b_hs", 32'(hs_count - hs0), 2);

        // Randomized traffic against the reference memory
        for (int t = 0; t < 300; t++) begin
            r  = int'($urandom_range(0, 9));
            ld = (r >= 1 && r <= 5);
            st = (r >= 6);
            if ($urandom_range(0, 4) == 0) f3 = 3'($urandom_range(0, 7));
            else if (st) f3 = 3'($urandom_range(0, 2));
            else begin
                r  = int'($urandom_range(0, 4));
                f3 = (r < 3) ? 3'(r) : 3'(r + 1);
            end
            do_op(ld, st, f3, 32'h5000 + $urandom_range(0, 63), $urandom,
                  5'($urandom_range(0, 31)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) next_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-stage load/store unit. Consumes the EX/MEM pipeline-register outputs for a memory instruction and runs one valid/ready transaction on the data-memory port.
- Performs store byte-lane steering and active-low bit-write-mask generation, plus load extraction and sign/zero extension.
- Holds the pipeline via lsu_stall until the access completes.
- Sits between the EX/MEM register and the MEM/WB register.

Parameters:
ADDR_W, 32, data-memory address width (low ADDR_W bits of M_addr driven out)

Ports:
clk  in  1  clock
rst  in  1  reset
M_valid  in  1  EX/MEM slot holds a live instruction
M_load  in  1  instruction is a load
M_store  in  1  instruction is a store (M_load && M_store never both 1)
M_funct3  in  3  RV32I load/store width code
M_addr  in  32  effective address (ALU output)
M_store_data  in  32  rs2 value for stores
M_rd  in  5  load destination register
dm_req_valid  out  1  request valid
dm_req_ready  in  1  memory accepts request
dm_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
dm_web  out  1  active-low write strobe (0 = write)
dm_bweb  out  32  active-low per-bit write mask
dm_wdata  out  32  lane-steered store data
dm_rsp_valid  in  1  read data valid
dm_rdata  in  32  read word
lsu_stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
W_load_valid  out  1  one-cycle pulse, formatted load result valid
W_load_rd  out  5  destination register for the load result
W_load_data  out  32  extended load result
lsu_fault  out  1  one-cycle pulse, misaligned or illegal access

Behaviour:
- Reset is asynchronous, active-high, on rst. Clock is clk.
- Reset values: state IDLE; dm_req_valid 0; dm_web 1; dm_bweb 32'hFFFFFFFF; dm_addr 0; dm_wdata 0; W_load_valid 0; W_load_rd 0; W_load_data 0; lsu_fault 0. lsu_stall is 0 while in reset.
- States: IDLE, REQ, WAIT, DONE.
- Memory op presented = M_valid && (M_load || M_store).
- Legal funct3 values:
  - loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
  - stores: 000 SB, 001 SH, 010 SW
  - anything else is illegal.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
- IDLE:
  - Memory op presented and legal and aligned: capture addr/data/funct3/rd into internal registers, next state REQ. lsu_stall=1 combinationally this cycle.
  - Memory op presented but illegal or misaligned: no request; lsu_fault=1 next cycle for exactly one cycle; lsu_stall=0.
  - Otherwise: stay in IDLE, lsu_stall=0.
- REQ:
  - dm_req_valid=1. Address, web, bweb and wdata are driven from the captured registers and stay stable until accepted.
  - On dm_req_ready: store goes to DONE; load goes to WAIT.
  - No timeout; ready held low keeps the FSM in REQ indefinitely.
- WAIT: dm_req_valid=0. On dm_rsp_valid, register the formatted load result and go to DONE.
- DONE:
  - W_load_valid=1 for loads only, with W_load_rd = captured rd. No W pulse for stores.
  - lsu_stall=0, so EX/MEM advances exactly once. M_* inputs are ignored this cycle. Next state IDLE.
- lsu_stall = (IDLE && op presented && legal && aligned) || REQ || WAIT.
- Latency (zero-wait memory): load presented in cycle 0 → REQ in cycle 1 → WAIT in cycle 2 → DONE / W_load_valid in cycle 3. Store: DONE in cycle 2.
- Store steering, with o = addr[1:0]:
  - SB: byte replicated on all 4 lanes; bweb byte-lane o = 0x00, other lanes 0xFF.
  - SH: halfword replicated on both halves; lane pair o[1] cleared.
  - SW: bweb all zeros.
  - dm_web=0 for stores, 1 for loads. Loads drive bweb all ones.
- Load extraction: byte/halfword selected by captured addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend.
- dm_rsp_valid outside WAIT is ignored.
- Reset mid-transaction: FSM returns to IDLE, request dropped, any later response ignored.
- W_load_data and W_load_rd hold their values between pulses.

Decomposition:
- Shared package lsu_pkg: state enum (IDLE, REQ, WAIT, DONE); funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU); opcode constants LOAD=7'b0000011 and STORE=7'b0100011 for the decoder feeding M_load/M_store.
- One combinational sub-module, lsu_align, used twice:
  - store path: funct3, offset, data → wdata, bweb
  - load path: funct3, offset, rdata → extended data
  - also outputs the legal/aligned flags.

Test Plan:
- SB, addr 0x1001, data 0x000000A5, ready=1 → REQ in cycle 1: dm_addr 0x1000, dm_web 0, dm_bweb 0xFFFF00FF, dm_wdata 0xA5A5A5A5; stall cycles 0–1; no W pulse.
- LB, addr 0x2003, rdata 0x80FF1234, response 1 cycle after accept → W_load_data 0xFFFFFF80, W_load_rd = M_rd, pulse in cycle 3. Repeat as LBU → 0x00000080.
- LH, addr 0x2002, dm_req_ready low for 3 cycles, rdata 0x7FFE0000 → request stable 4 cycles; W_load_data 0x00007FFE; stall held throughout REQ/WAIT.
- LW, addr 0x3001 → no dm_req_valid, lsu_fault pulses 1 cycle, lsu_stall never asserted. Repeat with funct3 011 → same response.
- Assert rst during WAIT, then pulse dm_rsp_valid → outputs at reset values, W_load_valid stays 0, FSM in IDLE.
- Back-to-back SW 0x4000 then LW 0x4000 → each op issues exactly one request; the load returns the stored word.
